// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: ALU codes, opcode/funct encodings and the
// issued ID/EX bundle type.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
    ALU_SLL  = 4'd4,  ALU_SRL  = 4'd5,  ALU_SRA  = 4'd6,  ALU_XOR  = 4'd7,
    ALU_LESS = 4'd8,  ALU_NOR  = 4'd9,  ALU_SLLV = 4'd10, ALU_SRLV = 4'd11,
    ALU_SRAV = 4'd12, ALU_ANDI = 4'd13, ALU_ORI  = 4'd14, ALU_XORI = 4'd15
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic [31:0] src_a;
    logic [31:0] src_b;
    alu_op_t     aluctr;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        regwrite;
    logic        illegal;
  } issue_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of one instruction word plus its forwarded register
// operands into the ALU issue bundle.
module alu_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output issue_t      issue_o
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [31:0] simm;
  logic        unused_rs;

  assign op        = instr_i[31:26];
  assign fn        = instr_i[5:0];
  assign simm      = {{16{instr_i[15]}}, instr_i[15:0]};
  assign unused_rs = ^instr_i[25:21];

  always_comb begin
    issue_o          = '0;
    issue_o.src_a    = rs_data_i;
    issue_o.src_b    = rt_data_i;
    issue_o.aluctr   = ALU_ADD;
    issue_o.regwrite = 1'b1;
    issue_o.dest     = instr_i[20:16];
    case (op)
      OP_RTYPE: begin
        issue_o.shamt = instr_i[10:6];
        issue_o.dest  = instr_i[15:11];
        case (fn)
          FN_ADD, FN_ADDU: issue_o.aluctr = ALU_ADD;
          FN_SUB, FN_SUBU: issue_o.aluctr = ALU_SUB;
          FN_AND:          issue_o.aluctr = ALU_AND;
          FN_OR:           issue_o.aluctr = ALU_OR;
          FN_XOR:          issue_o.aluctr = ALU_XOR;
          FN_NOR:          issue_o.aluctr = ALU_NOR;
          FN_SLT:          issue_o.aluctr = ALU_LESS;
          FN_SLL:          issue_o.aluctr = ALU_SLL;
          FN_SRL:          issue_o.aluctr = ALU_SRL;
          FN_SRA:          issue_o.aluctr = ALU_SRA;
          FN_SLLV:         issue_o.aluctr = ALU_SLLV;
          FN_SRLV:         issue_o.aluctr = ALU_SRLV;
          FN_SRAV:         issue_o.aluctr = ALU_SRAV;
          default:         issue_o.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: issue_o.src_b = simm;
      OP_SW: begin
        issue_o.src_b    = simm;
        issue_o.regwrite = 1'b0;
      end
      OP_SLTI: begin
        issue_o.src_b  = simm;
        issue_o.aluctr = ALU_LESS;
      end
      // ALU zero-extends for the logical immediates; we always sign-extend here
      OP_ANDI: begin
        issue_o.src_b  = simm;
        issue_o.aluctr = ALU_ANDI;
      end
      OP_ORI: begin
        issue_o.src_b  = simm;
        issue_o.aluctr = ALU_ORI;
      end
      OP_XORI: begin
        issue_o.src_b  = simm;
        issue_o.aluctr = ALU_XORI;
      end
      OP_BEQ, OP_BNE: begin
        issue_o.aluctr   = ALU_SUB;
        issue_o.regwrite = 1'b0;
      end
      OP_LUI: begin
        issue_o.src_a = '0;
        issue_o.src_b = {instr_i[15:0], 16'h0000};
      end
      default: begin
        issue_o.illegal = 1'b1;
        issue_o.dest    = '0;
      end
    endcase
    if (issue_o.illegal || issue_o.dest == 5'd0) issue_o.regwrite = 1'b0;
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes into the ALU bundle and holds it behind a
// valid/ready handshake. Define ALU_ISSUE_SKID_EN for the registered-ready skid build.
module id_ex_alu_issue
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_srcA,
  output logic [XLEN-1:0] ex_srcB,
  output logic [3:0]      ex_aluctr,
  output logic [4:0]      ex_shamt,
  output logic [4:0]      ex_dest,
  output logic            ex_regwrite,
  output logic            ex_illegal
);

  issue_t dec;
  issue_t out_q;
  logic   valid_q;
  logic   acc;
  logic   drn;

  alu_decode u_dec (
    .instr_i   (id_instr),
    .rs_data_i (id_rs_data),
    .rt_data_i (id_rt_data),
    .issue_o   (dec)
  );

  assign acc = id_valid && id_ready;
  assign drn = valid_q && ex_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q;
  logic   skid_v_q;
  logic   ready_q;

  // ready_q always equals !skid_v_q, so an accept never meets a full skid
  assign id_ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
    end else if (flush) begin
      valid_q  <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
    end else if (skid_v_q) begin
      if (drn) begin
        out_q    <= skid_q;
        skid_v_q <= 1'b0;
        ready_q  <= 1'b1;
      end
    end else if (acc) begin
      if (!valid_q || drn) begin
        out_q   <= dec;
        valid_q <= 1'b1;
      end else begin
        skid_q   <= dec;
        skid_v_q <= 1'b1;
        ready_q  <= 1'b0;
      end
    end else if (drn) begin
      valid_q <= 1'b0;
    end
  end
`else
  assign id_ready = !valid_q || ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (acc) begin
      out_q   <= dec;
      valid_q <= 1'b1;
    end else if (drn) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign ex_valid    = valid_q;
  assign ex_srcA     = out_q.src_a;
  assign ex_srcB     = out_q.src_b;
  assign ex_aluctr   = out_q.aluctr;
  assign ex_shamt    = out_q.shamt;
  assign ex_dest     = out_q.dest;
  assign ex_regwrite = out_q.regwrite;
  assign ex_illegal  = out_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed self-checking bench for id_ex_alu_issue (plain and skid builds).
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_srcA;
  logic [31:0] ex_srcB;
  logic [3:0]  ex_aluctr;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_dest;
  logic        ex_regwrite;
  logic        ex_illegal;

  int n_chk  = 0;
  int n_pass = 0;
  int cur_k;
  int last_k;
  int exp_k;
  int got_n;
  logic [31:0] got [16];

  always #5 clk = ~clk;

  id_ex_alu_issue #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_srcA     (ex_srcA),
    .ex_srcB     (ex_srcB),
    .ex_aluctr   (ex_aluctr),
    .ex_shamt    (ex_shamt),
    .ex_dest     (ex_dest),
    .ex_regwrite (ex_regwrite),
    .ex_illegal  (ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic vec(input string tag, input logic [31:0] instr, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [3:0] a, input logic [31:0] sa,
                     input logic [31:0] sb, input logic [4:0] sh, input logic [4:0] d,
                     input logic rw);
    id_instr = instr; id_rs_data = rs; id_rt_data = rt;
    @(posedge clk); #1;
    chk({tag, ".valid"},   32'(ex_valid),    32'd1);
    chk({tag, ".aluctr"},  32'(ex_aluctr),   32'(a));
    chk({tag, ".srcA"},    ex_srcA,          sa);
    chk({tag, ".srcB"},    ex_srcB,          sb);
    chk({tag, ".shamt"},   32'(ex_shamt),    32'(sh));
    chk({tag, ".dest"},    32'(ex_dest),     32'(d));
    chk({tag, ".regwr"},   32'(ex_regwrite), 32'(rw));
    chk({tag, ".illegal"}, 32'(ex_illegal),  32'd0);
  endtask

  // addi $1,$0,k : srcB carries the sequence tag k
  task automatic drive_k();
    id_instr   = 32'h2001_0000 | {16'h0, cur_k[15:0]};
    id_rs_data = '0;
    id_rt_data = '0;
    id_valid   = (cur_k <= last_k);
  endtask

  task automatic tick();
    logic acc, drn;
    @(negedge clk);
    acc = id_valid && id_ready;
    drn = ex_valid && ex_ready;
    if (drn && got_n < 16) begin
      got[got_n] = ex_srcB;
      got_n++;
    end
    @(posedge clk); #1;
    if (acc) cur_k++;
    drive_k();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b1;
    id_instr = 32'h2108_FFFF; id_rs_data = 32'h11; id_rt_data = 32'h22;
    got_n = 0; cur_k = 0; last_k = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid",  32'(ex_valid),    32'd0);
    chk("rst.aluctr", 32'(ex_aluctr),   32'd0);
    chk("rst.srcA",   ex_srcA,          32'd0);
    chk("rst.srcB",   ex_srcB,          32'd0);
    chk("rst.dest",   32'(ex_dest),     32'd0);
    chk("rst.regwr",  32'(ex_regwrite), 32'd0);
    chk("rst.illeg",  32'(ex_illegal),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.ready",  32'(id_ready),    32'd1);

    vec("addi", 32'h2108_FFFF, 32'h11,  32'h22, 4'd0,  32'h11,  32'hFFFF_FFFF, 5'd0, 5'd8, 1'b1);
    vec("sll",  32'h0003_1100, 32'h55,  32'h3,  4'd4,  32'h55,  32'h3,         5'd4, 5'd2, 1'b1);
    vec("lui",  32'h3C05_1234, 32'h77,  32'h0,  4'd0,  32'h0,   32'h1234_0000, 5'd0, 5'd5, 1'b1);
    vec("sw",   32'hAC45_0010, 32'h100, 32'h9,  4'd0,  32'h100, 32'h10,        5'd0, 5'd5, 1'b0);
    vec("beq",  32'h1045_0003, 32'h1,   32'h9,  4'd1,  32'h1,   32'h9,         5'd0, 5'd5, 1'b0);
    vec("ori",  32'h34A6_FFFF, 32'h2,   32'h0,  4'd14, 32'h2,   32'hFFFF_FFFF, 5'd0, 5'd6, 1'b1);
    vec("add0", 32'h0022_0020, 32'h4,   32'h5,  4'd0,  32'h4,   32'h5,         5'd0, 5'd0, 1'b0);
    vec("slt",  32'h0043_202A, 32'h4,   32'h5,  4'd8,  32'h4,   32'h5,         5'd0, 5'd4, 1'b1);
    vec("srav", 32'h0043_2147, 32'h6,   32'h7,  4'd12, 32'h6,   32'h7,         5'd5, 5'd4, 1'b1);

    id_instr = 32'hFC00_0000;
    @(posedge clk); #1;
    chk("ill.valid",  32'(ex_valid),    32'd1);
    chk("ill.flag",   32'(ex_illegal),  32'd1);
    chk("ill.regwr",  32'(ex_regwrite), 32'd0);
    chk("ill.aluctr", 32'(ex_aluctr),   32'd0);

    // stall: tags 1..5, output frozen for three cycles
    cur_k = 6; last_k = 5; drive_k();
    tick();
    got_n = 0; cur_k = 1; drive_k();
    tick();
    ex_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall.srcB",  ex_srcB,          32'd1);
      chk("stall.valid", 32'(ex_valid),    32'd1);
      chk("stall.ready", 32'(id_ready),    32'd0);
    end
`ifdef ALU_ISSUE_SKID_EN
    chk("stall.taken", 32'(cur_k), 32'd3);
`else
    chk("stall.taken", 32'(cur_k), 32'd2);
`endif
    chk("stall.nodrain", 32'(got_n), 32'd0);
    ex_ready = 1'b1;
    repeat (12) tick();
    chk("order.count", 32'(got_n), 32'd5);
    for (int i = 0; i < 5; i++) chk("order.tag", got[i], 32'(i + 1));

    // flush during stall, then flush over a simultaneous accept
    cur_k = 10; last_k = 14; drive_k();
    tick();
    ex_ready = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    chk("flush.valid", 32'(ex_valid), 32'd0);
    chk("flush.ready", 32'(id_ready), 32'd1);
    ex_ready = 1'b1;
    tick();
    chk("flushacc.valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; got_n = 0; exp_k = cur_k; last_k = cur_k; drive_k();
    repeat (4) tick();
    chk("flush.count", 32'(got_n), 32'd1);
    chk("flush.tag",   got[0],     32'(exp_k));

    // reset asserted mid-stall
    cur_k = 20; last_k = 22; drive_k();
    tick();
    ex_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid.valid", 32'(ex_valid), 32'd0);
    chk("rstmid.ready", 32'(id_ready), 32'd1);
    id_valid = 1'b0; last_k = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; ex_ready = 1'b1; got_n = 0;
    repeat (3) tick();
    chk("rstmid.nostale", 32'(got_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
# id_ex_alu_issue

Decode-and-issue stage that sits between the register-file read in ID and the ALU in EX of the 5-stage MIPS pipeline. It takes a fetched instruction word plus the two register read values and produces the ALU control code, operands and shift amount. It captures them in the ID/EX pipeline register behind a valid/ready handshake with stall and flush support. This block is the producer side of the ALU's `aluctr`/`srcA`/`srcB`/`shamt` interface.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: instruction and operands on the `id_*` inputs are valid.
- `id_ready` out 1: stage accepts `id_*` this cycle.
- `id_instr` in 32: instruction word.
- `id_rs_data` in 32: GPR[rs] value, already forwarded.
- `id_rt_data` in 32: GPR[rt] value, already forwarded.
- `flush` in 1: kill all held entries; the highest-priority event.
- `ex_valid` out 1: EX-side outputs are valid.
- `ex_ready` in 1: EX consumes the entry this cycle.
- `ex_srcA` out 32: ALU operand A.
- `ex_srcB` out 32: ALU operand B.
- `ex_aluctr` out 4: ALU operation code.
- `ex_shamt` out 5: shift amount.
- `ex_dest` out 5: destination register.
- `ex_regwrite` out 1: the result is written back.
- `ex_illegal` out 1: the opcode/funct pair is unsupported.

## Operation
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, SLL 4, SRL 5, SRA 6, XOR 7, LESS 8, NOR 9, SLLV 10, SRLV 11, SRAV 12, ANDI 13, ORI 14, XORI 15.
- R-type (opcode 0), by funct:
  - add/addu (0x20/0x21) → ADD; sub/subu (0x22/0x23) → SUB.
  - and 0x24 → AND; or 0x25 → OR; xor 0x26 → XOR; nor 0x27 → NOR; slt 0x2A → LESS.
  - sll 0x00 → SLL; srl 0x02 → SRL; sra 0x03 → SRA.
  - sllv 0x04 → SLLV; srlv 0x06 → SRLV; srav 0x07 → SRAV.
  - Operands: srcA = rs_data, srcB = rt_data, shamt = instr[10:6], dest = rd.
- I-type:
  - addi/addiu (0x08/0x09) → ADD; slti 0x0A → LESS.
  - andi 0x0C → ANDI; ori 0x0D → ORI; xori 0x0E → XORI.
  - lw 0x23 and sw 0x2B → ADD; beq 0x04 and bne 0x05 → SUB with srcB = rt_data.
  - Operands: srcA = rs_data, srcB = sign-extended imm16 (the ALU zero-extends for ANDI/ORI/XORI), dest = rt, shamt = 0.
- lui 0x0F: ADD, srcA = 0, srcB = {imm16, 16'h0}, dest = rt.
- regwrite: 1 for all writing ops. It is 0 for sw, beq and bne, and 0 whenever dest == 0.
- Unsupported encoding: aluctr = ADD, regwrite = 0, illegal = 1. The entry still flows through the stage.
- Accept: `id_valid && id_ready`. Drain: `ex_valid && ex_ready`.

## Timing
- Latency is one cycle. An instruction accepted at edge N appears on `ex_*` after edge N.
- Reset values: `ex_valid`=0, `ex_illegal`=0, `ex_regwrite`=0, `ex_aluctr`=0, and all data outputs 0. `id_ready` is 1 once reset is released.
- `ex_*` outputs hold stable while `ex_valid && !ex_ready`. No `ex_*` output changes during a stall.
- `flush` clears `ex_valid` and any skid entry at the next edge and discards a simultaneous accept.
- Reset asserted mid-stall discards all entries immediately; no partial entry survives.
- Simultaneous accept and drain: the new entry replaces the drained one, with no bubble.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Two-entry skid buffer; `id_ready` is a register output with no combinational path from `ex_ready`.
  - `id_ready` = skid buffer empty.
  - An accept that lands while the output is stalled goes into the skid entry.
  - The skid entry moves to the output on the next drain.
  - Full throughput is maintained.
- Not defined:
  - Single register.
  - `id_ready = !ex_valid || ex_ready`, combinational.

## Structure
- Shared package `mips_pkg`:
  - ALU code constants (the 16 above).
  - Opcode and funct constants.
  - A struct type for the issued bundle (srcA, srcB, aluctr, shamt, dest, regwrite, illegal).
- One sub-module `alu_decode`: purely combinational, instr + operands → bundle. The top level holds the handshake registers and the skid buffer.

## Test plan
- Reset: drive `rst_n`=0, then `id_valid`=1 with `id_instr`=0x2108FFFF → all `ex_*` are 0 and `ex_valid`=0. After release, one cycle later: aluctr 0, srcB 0xFFFFFFFF, dest 8, regwrite 1.
- sll: `id_instr`=0x00031100 with rt_data=0x3 → aluctr 4, shamt 4, dest 2, srcB 0x3.
- lui and sw: `id_instr`=0x3C051234 → srcA 0, srcB 0x12340000, dest 5. An sw (0xAC...) → regwrite 0.
- Stall: hold `ex_ready`=0 for 3 cycles with `id_valid`=1 → outputs frozen. In non-skid builds `id_ready`=0. In skid builds one extra entry is accepted and then `id_ready`=0. After release, in-order delivery with no loss or duplication.
- Flush during stall with a pending accept → `ex_valid`=0 next cycle and the skid buffer is empty.
- Illegal: opcode 0x3F → illegal 1, regwrite 0, aluctr 0.
